// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard and forwarding controller: a per-register scoreboard of
// in-flight writes with per-write latency, driving stall and rs/rt forward selects.
module hazard_scoreboard #(
    parameter int unsigned NUM_REGS  = 32,
    parameter int unsigned LAT_ALU   = 1,
    parameter int unsigned LAT_LOAD  = 2,
    parameter int unsigned LAT_MUL   = 3,
    parameter int unsigned FWD_DEPTH = 3,
    localparam int unsigned AW = $clog2(NUM_REGS),
    localparam int unsigned FW = $clog2(FWD_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic [AW-1:0] id_rs_addr,
    input  logic [AW-1:0] id_rt_addr,
    input  logic          id_rs_used,
    input  logic          id_rt_used,
    input  logic          id_we,
    input  logic [AW-1:0] id_wr_addr,
    input  logic [1:0]    id_lat_class,
    input  logic          freeze,
    output logic          stall,
    output logic [FW-1:0] fwd_rs_sel,
    output logic [FW-1:0] fwd_rt_sel,
    output logic          pending_any
);

    localparam int unsigned CW       = $clog2(LAT_MUL + 1);
    localparam int unsigned AGE_MAX  = FWD_DEPTH + 1;
    localparam int unsigned GW       = $clog2(FWD_DEPTH + 2);

    logic [CW-1:0] cnt [NUM_REGS];
    logic [GW-1:0] age [NUM_REGS];

    logic [CW-1:0] lat;
    logic          rs_raw;
    logic          rt_raw;
    logic          waw;
    logic          issue;

    // Age k maps directly onto forwarding source k; anything older reads the register file.
    function automatic logic [FW-1:0] sel_of(input logic [GW-1:0] a);
        if (a >= GW'(1) && a <= GW'(FWD_DEPTH)) begin
            return FW'(a);
        end
        return '0;
    endfunction

    always_comb begin
        lat = CW'(LAT_MUL);
        case (id_lat_class)
            2'd0:    lat = CW'(LAT_ALU);
            2'd1:    lat = CW'(LAT_LOAD);
            default: lat = CW'(LAT_MUL);
        endcase
    end

    // A source is forwardable once its counter is at most 1; anything larger must wait.
    always_comb begin
        rs_raw = id_rs_used && (cnt[id_rs_addr] > CW'(1));
        rt_raw = id_rt_used && (cnt[id_rt_addr] > CW'(1));
        waw    = id_we && (id_wr_addr != '0) && (cnt[id_wr_addr] > lat);
        stall  = id_valid && (rs_raw || rt_raw || waw);
        issue  = id_valid && !stall && !freeze;
    end

    always_comb begin
        fwd_rs_sel = '0;
        fwd_rt_sel = '0;
        if (id_rs_used && id_rs_addr != '0) begin
            fwd_rs_sel = sel_of(age[id_rs_addr]);
        end
        if (id_rt_used && id_rt_addr != '0) begin
            fwd_rt_sel = sel_of(age[id_rt_addr]);
        end
    end

    always_comb begin
        pending_any = 1'b0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            pending_any = pending_any | (cnt[r] != '0);
        end
    end

    // r0 keeps its reset values forever; a stalled but unfrozen cycle still ages entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
                age[r] <= GW'(AGE_MAX);
            end
        end else if (!freeze) begin
            for (int unsigned r = 1; r < NUM_REGS; r++) begin
                if (issue && id_we && (AW'(r) == id_wr_addr)) begin
                    cnt[r] <= lat;
                    age[r] <= GW'(1);
                end else begin
                    if (cnt[r] != '0) begin
                        cnt[r] <= cnt[r] - CW'(1);
                    end
                    if (age[r] != GW'(AGE_MAX)) begin
                        age[r] <= age[r] + GW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: per-cycle expectations are queued
// when stimulus is driven and popped when outputs are sampled at the negedge.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs_addr;
    logic [4:0] id_rt_addr;
    logic       id_rs_used;
    logic       id_rt_used;
    logic       id_we;
    logic [4:0] id_wr_addr;
    logic [1:0] id_lat_class;
    logic       freeze;
    logic       stall;
    logic [1:0] fwd_rs_sel;
    logic [1:0] fwd_rt_sel;
    logic       pending_any;

    typedef struct {
        int stall;
        int rs_sel;
        int rt_sel;
        int pend;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   step_n = 0;

    hazard_scoreboard dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs_addr   (id_rs_addr),
        .id_rt_addr   (id_rt_addr),
        .id_rs_used   (id_rs_used),
        .id_rt_used   (id_rt_used),
        .id_we        (id_we),
        .id_wr_addr   (id_wr_addr),
        .id_lat_class (id_lat_class),
        .freeze       (freeze),
        .stall        (stall),
        .fwd_rs_sel   (fwd_rs_sel),
        .fwd_rt_sel   (fwd_rt_sel),
        .pending_any  (pending_any)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    // Pop the oldest expectation and compare it against the live outputs; -1 means don't care.
    task automatic compare_now();
        exp_t e;
        if (exp_q.size() == 0) begin
            check($sformatf("queue_empty@%0d", step_n), 0, 1);
        end else begin
            e = exp_q.pop_front();
            check($sformatf("stall@%0d", step_n), int'(stall), e.stall);
            if (e.rs_sel >= 0) check($sformatf("rs_sel@%0d", step_n), int'(fwd_rs_sel), e.rs_sel);
            if (e.rt_sel >= 0) check($sformatf("rt_sel@%0d", step_n), int'(fwd_rt_sel), e.rt_sel);
            check($sformatf("pend@%0d", step_n), int'(pending_any), e.pend);
        end
        step_n++;
    endtask

    task automatic drive(input logic v, input logic rsu, input int rs, input logic rtu, input int rt,
                         input logic we, input int wr, input int cls, input logic frz);
        id_valid     = v;
        id_rs_used   = rsu;
        id_rs_addr   = 5'(rs);
        id_rt_used   = rtu;
        id_rt_addr   = 5'(rt);
        id_we        = we;
        id_wr_addr   = 5'(wr);
        id_lat_class = 2'(cls);
        freeze       = frz;
    endtask

    task automatic expect_out(input int s, input int rss, input int rts, input int p);
        exp_t e;
        e.stall  = s;
        e.rs_sel = rss;
        e.rt_sel = rts;
        e.pend   = p;
        exp_q.push_back(e);
    endtask

    // One decode cycle: sample at the negedge, then advance past the next rising edge.
    task automatic cyc_end();
        @(negedge clk);
        compare_now();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int p);
        drive(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 0, 1'b0);
        expect_out(0, 0, 0, p);
        cyc_end();
    endtask

    // Reader-only instruction on rs and/or rt.
    task automatic rd(input int rs, input logic rsu, input int rt, input logic rtu, input logic frz,
                      input int s, input int rss, input int rts, input int p);
        drive(1'b1, rsu, rs, rtu, rt, 1'b0, 0, 0, frz);
        expect_out(s, rss, rts, p);
        cyc_end();
    endtask

    // Writer with no source reads.
    task automatic wr_op(input int wr, input int cls, input int s, input int p);
        drive(1'b1, 1'b0, 0, 1'b0, 0, 1'b1, wr, cls, 1'b0);
        expect_out(s, 0, 0, p);
        cyc_end();
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 0, 1'b0);
        #2;
        expect_out(0, 0, 0, 0);
        compare_now();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Load-use: one bubble, then forward from age 2.
        wr_op(5, 1, 0, 0);
        drive(1'b1, 1'b1, 5, 1'b0, 0, 1'b1, 6, 0, 1'b0);
        expect_out(1, -1, 0, 1);
        cyc_end();
        drive(1'b1, 1'b1, 5, 1'b0, 0, 1'b1, 6, 0, 1'b0);
        expect_out(0, 2, 0, 1);
        cyc_end();
        idle(1);
        idle(0);

        // ALU back-to-back, rs==rt selects match.
        wr_op(8, 0, 0, 0);
        rd(8, 1'b1, 8, 1'b1, 1'b0, 0, 1, 1, 1);
        rd(0, 1'b0, 8, 1'b1, 1'b0, 0, 0, 2, 0);

        // MUL dependency: two bubbles, then age 3.
        wr_op(10, 2, 0, 0);
        rd(10, 1'b1, 0, 1'b0, 1'b0, 1, -1, 0, 1);
        rd(10, 1'b1, 0, 1'b0, 1'b0, 1, -1, 0, 1);
        rd(10, 1'b1, 0, 1'b0, 1'b0, 0, 3, 0, 1);
        idle(0);

        // WAW: younger ALU write waits until the MUL counter is <= 1.
        wr_op(12, 2, 0, 0);
        wr_op(12, 0, 1, 1);
        wr_op(12, 0, 1, 1);
        wr_op(12, 0, 0, 1);
        rd(12, 1'b1, 0, 1'b0, 1'b0, 0, 1, 0, 1);
        idle(0);

        // Freeze holds the scoreboard; stall resolves only after freeze drops.
        wr_op(4, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            rd(4, 1'b1, 0, 1'b0, 1'b1, 1, -1, 0, 1);
        end
        rd(4, 1'b1, 0, 1'b0, 1'b0, 1, -1, 0, 1);
        rd(4, 1'b1, 0, 1'b0, 1'b0, 0, 2, 0, 1);
        idle(0);

        // r0 is never tracked.
        wr_op(0, 2, 0, 0);
        rd(0, 1'b1, 0, 1'b1, 1'b0, 0, 0, 0, 0);

        // Reserved class behaves as MUL.
        wr_op(7, 3, 0, 0);
        rd(0, 1'b0, 7, 1'b1, 1'b0, 1, 0, -1, 1);

        // Mid-operation reset clears the scoreboard immediately.
        idle(1);
        idle(1);
        idle(0);
        wr_op(9, 2, 0, 0);
        drive(1'b1, 1'b1, 9, 1'b0, 0, 1'b0, 0, 0, 1'b0);
        expect_out(1, -1, 0, 1);
        #2;
        compare_now();
        rst = 1'b1;
        #2;
        expect_out(0, 0, 0, 0);
        compare_now();
        @(posedge clk);
        #1;
        rst = 1'b0;
        rd(9, 1'b1, 0, 1'b0, 1'b0, 0, 0, 0, 0);

        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised hazard and forwarding controller for the decode stage of the 5-stage MIPS pipeline.
- Keeps a per-register scoreboard of in-flight writes. Each write carries its own result latency: ALU, load, or multi-cycle MUL.
- From that scoreboard it produces the decode stall and the forwarding-source selects for rs/rt.
- It replaces the fixed EX/MEM compare logic in decode, so longer-latency units can be added without rewriting the hazard equations.

Parameters:
NUM_REGS, 32, number of architectural registers; address width is clog2(NUM_REGS).
LAT_ALU, 1, cycles from issue until an ALU result is forwardable.
LAT_LOAD, 2, cycles from issue until load data is forwardable.
LAT_MUL, 3, cycles from issue until a MUL result is forwardable.
FWD_DEPTH, 3, number of forwarding sources (age 1..FWD_DEPTH); must be >= max latency.

Ports:
clk  in  1  clock.
rst  in  1  reset, asynchronous, active-high.
id_valid  in  1  decode holds a real instruction.
id_rs_addr  in  AW  rs source register.
id_rt_addr  in  AW  rt source register.
id_rs_used  in  1  instruction reads rs.
id_rt_used  in  1  instruction reads rt.
id_we  in  1  instruction writes a register.
id_wr_addr  in  AW  destination register.
id_lat_class  in  2  latency class: 0=ALU, 1=LOAD, 2=MUL, 3=reserved (treated as MUL).
freeze  in  1  external pipeline freeze (memory wait).
stall  out  1  hold decode and insert a bubble into EX.
fwd_rs_sel  out  FW  0=register file; k=forward from the stage of age k.
fwd_rt_sel  out  FW  as fwd_rs_sel, for rt.
pending_any  out  1  at least one scoreboard counter is nonzero.
FW = clog2(FWD_DEPTH+1).

Behaviour:
- State per register r:
  - cnt[r]: cycles until the result is forwardable; width holds LAT_MUL.
  - age[r]: cycles since the youngest writer issued; saturates at FWD_DEPTH+1.
- Register 0 is never tracked: cnt[0]=0 and age[0]=FWD_DEPTH+1 permanently. Writes to r0 are ignored.
- Reset (async) and on every asserted rst, including mid-operation:
  - all cnt=0;
  - all age=FWD_DEPTH+1;
  - outputs stall=0, fwd selects=0, pending_any=0.
- Combinational outputs are derived from registered state plus id_* inputs only.
- Stall is the OR of three terms, each gated by id_valid:
  - rs RAW: id_rs_used & cnt[rs]>1.
  - rt RAW: id_rt_used & cnt[rt]>1.
  - WAW: id_we & wr!=0 & cnt[wr] > LAT(class). This prevents an older, slower write landing after a younger one.
- Issue = id_valid & ~stall & ~freeze.
- Forwarding select: fwd_x_sel = age[x] if 1<=age[x]<=FWD_DEPTH, else 0.
  - It is valid only when stall=0. Drive 0 when the used flag is 0 or addr=0.
  - Example: ALU producer at age 1 selects EX; load at age 2 selects MEM; MUL at age 3 selects WB/MUL-result.
- Per-register update at the clock edge:
  - If freeze=1, nothing changes (cnt and age hold).
  - Else if issue & id_we & r==wr & r!=0: cnt[r]<=LAT(class); age[r]<=1.
  - Else: cnt[r]<=cnt[r]-1 if nonzero; age[r]<=age[r]+1, saturating at FWD_DEPTH+1.
- A stalled cycle (not frozen) still ages all entries. This is how a load-use stall resolves after one bubble.
- Source equals destination in the same instruction: the hazard check uses pre-update state, and the new entry is loaded after the check.
- rs==rt: both selects are identical; stall is counted once (OR).
- pending_any = OR of all cnt != 0.
- Latency: stall and fwd selects respond in the same cycle as id_* changes. Scoreboard updates take effect in the following cycle.

Test Plan:
- Load-use: issue LOAD wr=5; next cycle ALU reads rs=5 -> stall=1 for 1 cycle; the following cycle stall=0, fwd_rs_sel=2.
- ALU back-to-back: ALU wr=8; next instr reads rt=8 -> stall=0, fwd_rt_sel=1. One cycle later a reader of r8 gets fwd_rt_sel=2.
- MUL dependency: MUL wr=10; reader of r10 next cycle -> stall=1, 1, then 0 with fwd sel=3. pending_any falls 3 cycles after issue.
- WAW: MUL wr=12, then immediately ALU wr=12 -> stall=1 (cnt 3 > 1) until cnt<=1. The ALU then issues; a later reader selects age 1.
- Freeze: LOAD wr=4, freeze=1 for 3 cycles with a reader of r4 -> stall stays 1 and cnt stays 2. After freeze drops: stall 1 cycle, then fwd sel 2.
- r0 and reset: MUL wr=0 then reader of r0 -> no stall, sel 0. Assert rst while MUL wr=9 is pending -> stall=0, pending_any=0 immediately; a reader of r9 gets sel 0.
